// File: rtl/vx_tcu_tile_engine_if.sv
// ---------------------------------------------------------------------------
// vx_tcu_tile_engine_if
//   Handshake and data bundle between the TCU control FSM (master) and the
//   tile compute engine (slave).
//
//   Master drives : load_start, acc_en, load_valid, load_data_a, load_data_b,
//                   store_start, store_ready
//   Slave drives  : load_ready, load_done, exec_done, store_valid,
//                   store_data, store_idx, store_done, busy
// ---------------------------------------------------------------------------
interface vx_tcu_tile_engine_if #(
    parameter int TILE_N     = 2,
    parameter int DATA_WIDTH = 32
);
    localparam int IDX_W = (TILE_N * TILE_N > 1) ? $clog2(TILE_N * TILE_N) : 1;

    logic                  load_start;
    logic                  acc_en;
    logic                  load_valid;
    logic                  load_ready;
    logic [DATA_WIDTH-1:0] load_data_a;
    logic [DATA_WIDTH-1:0] load_data_b;
    logic                  load_done;
    logic                  exec_done;
    logic                  store_start;
    logic                  store_valid;
    logic                  store_ready;
    logic [DATA_WIDTH-1:0] store_data;
    logic [IDX_W-1:0]      store_idx;
    logic                  store_done;
    logic                  busy;

    modport master (
        output load_start, acc_en, load_valid, load_data_a, load_data_b,
               store_start, store_ready,
        input  load_ready, load_done, exec_done, store_valid, store_data,
               store_idx, store_done, busy
    );

    modport slave (
        input  load_start, acc_en, load_valid, load_data_a, load_data_b,
               store_start, store_ready,
        output load_ready, load_done, exec_done, store_valid, store_data,
               store_idx, store_done, busy
    );
endinterface

// File: rtl/vx_tcu_tile_engine.sv
// ---------------------------------------------------------------------------
// vx_tcu_tile_engine
//   Tile compute engine: loads TILE_N x TILE_N operand tiles A and B
//   (row-major, one element pair per beat), computes C = A*B or C += A*B with
//   one MAC per cycle (i, j, k loop order, k innermost), holds C until asked,
//   then streams C out one element per beat. Arithmetic wraps modulo
//   2^DATA_WIDTH.
//
//   Ports:
//     clk    - clock
//     reset  - asynchronous, active-high
//     bus    - vx_tcu_tile_engine_if.slave (load/exec/store handshakes)
//
//   Phases: IDLE -> LOAD -> EXEC -> HOLD -> STORE -> IDLE.
//   load_done / exec_done / store_done are registered one-cycle pulses seen
//   in the first cycle of the following phase.
// ---------------------------------------------------------------------------
module vx_tcu_tile_engine #(
    parameter int TILE_N     = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    vx_tcu_tile_engine_if.slave        bus
);
    localparam int NE = TILE_N * TILE_N;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;
    localparam int CW = (TILE_N > 1) ? $clog2(TILE_N) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NE - 1);
    localparam logic [CW-1:0] CTR_LAST = CW'(TILE_N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EXEC  = 3'd2,
        S_HOLD  = 3'd3,
        S_STORE = 3'd4
    } state_t;

    // Row-major flattening of (row, col) into a tile element index.
    function automatic logic [IW-1:0] flat(input logic [CW-1:0] r,
                                           input logic [CW-1:0] c);
        int t;
        t = int'(r) * TILE_N + int'(c);
        return t[IW-1:0];
    endfunction

    // Product truncated to DATA_WIDTH (modular wrap, no saturation).
    function automatic logic signed [DATA_WIDTH-1:0] wrap_mul(
        input logic signed [DATA_WIDTH-1:0] x,
        input logic signed [DATA_WIDTH-1:0] y);
        logic signed [2*DATA_WIDTH-1:0] p;
        p = (2*DATA_WIDTH)'(x) * (2*DATA_WIDTH)'(y);
        return p[DATA_WIDTH-1:0];
    endfunction

    // Sum truncated to DATA_WIDTH (modular wrap, no saturation).
    function automatic logic signed [DATA_WIDTH-1:0] wrap_add(
        input logic signed [DATA_WIDTH-1:0] x,
        input logic signed [DATA_WIDTH-1:0] y);
        return x + y;
    endfunction

    state_t                        state_q, state_d;
    logic                          acc_q, acc_d;
    logic [IW-1:0]                 load_idx_q, load_idx_d;
    logic [CW-1:0]                 i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [DATA_WIDTH-1:0]  a_q [NE];
    logic signed [DATA_WIDTH-1:0]  a_d [NE];
    logic signed [DATA_WIDTH-1:0]  b_q [NE];
    logic signed [DATA_WIDTH-1:0]  b_d [NE];
    logic signed [DATA_WIDTH-1:0]  c_q [NE];
    logic signed [DATA_WIDTH-1:0]  c_d [NE];
    logic                          load_ready_q, load_ready_d;
    logic                          load_done_q, load_done_d;
    logic                          exec_done_q, exec_done_d;
    logic                          store_valid_q, store_valid_d;
    logic                          store_done_q, store_done_d;
    logic signed [DATA_WIDTH-1:0]  store_data_q, store_data_d;
    logic [IW-1:0]                 store_idx_q, store_idx_d;

    // MAC datapath for the current (i, j, k) step
    logic [IW-1:0]                 a_idx, b_idx, c_idx, store_nxt;
    logic signed [DATA_WIDTH-1:0]  mac_base, mac_sum;

    always_comb begin
        a_idx     = flat(i_q, k_q);
        b_idx     = flat(k_q, j_q);
        c_idx     = flat(i_q, j_q);
        // First k of a fresh (non-accumulating) pass starts from zero.
        mac_base  = ((k_q != '0) || acc_q) ? c_q[c_idx] : '0;
        mac_sum   = wrap_add(mac_base, wrap_mul(a_q[a_idx], b_q[b_idx]));
        store_nxt = store_idx_q + IW'(1);
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        load_idx_d    = load_idx_q;
        i_d           = i_q;
        j_d           = j_q;
        k_d           = k_q;
        a_d           = a_q;
        b_d           = b_q;
        c_d           = c_q;
        load_ready_d  = load_ready_q;
        load_done_d   = 1'b0;
        exec_done_d   = 1'b0;
        store_done_d  = 1'b0;
        store_valid_d = store_valid_q;
        store_data_d  = store_data_q;
        store_idx_d   = store_idx_q;

        case (state_q)
            S_IDLE: begin
                // load_start has priority; store_start is meaningless here.
                if (bus.load_start) begin
                    state_d      = S_LOAD;
                    acc_d        = bus.acc_en;
                    load_idx_d   = '0;
                    load_ready_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (bus.load_valid && load_ready_q) begin
                    a_d[load_idx_q] = $signed(bus.load_data_a);
                    b_d[load_idx_q] = $signed(bus.load_data_b);
                    if (load_idx_q == IDX_LAST) begin
                        load_idx_d   = '0;
                        load_ready_d = 1'b0;
                        load_done_d  = 1'b1;
                        i_d          = '0;
                        j_d          = '0;
                        k_d          = '0;
                        state_d      = S_EXEC;
                    end else begin
                        load_idx_d = load_idx_q + IW'(1);
                    end
                end
            end
            S_EXEC: begin
                c_d[c_idx] = mac_sum;
                if (k_q == CTR_LAST) begin
                    k_d = '0;
                    if (j_q == CTR_LAST) begin
                        j_d = '0;
                        if (i_q == CTR_LAST) begin
                            i_d         = '0;
                            exec_done_d = 1'b1;
                            state_d     = S_HOLD;
                        end else begin
                            i_d = i_q + CW'(1);
                        end
                    end else begin
                        j_d = j_q + CW'(1);
                    end
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (bus.store_start) begin
                    state_d       = S_STORE;
                    store_valid_d = 1'b1;
                    store_idx_d   = '0;
                    store_data_d  = c_q[0];
                end
            end
            S_STORE: begin
                if (store_valid_q && bus.store_ready) begin
                    if (store_idx_q == IDX_LAST) begin
                        store_valid_d = 1'b0;
                        store_idx_d   = '0;
                        store_data_d  = '0;
                        store_done_d  = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        store_idx_d  = store_nxt;
                        store_data_d = c_q[store_nxt];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register stage: all state, operand/result arrays and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            acc_q         <= 1'b0;
            load_idx_q    <= '0;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            for (int e = 0; e < NE; e++) begin
                a_q[e] <= '0;
                b_q[e] <= '0;
                c_q[e] <= '0;
            end
            load_ready_q  <= 1'b0;
            load_done_q   <= 1'b0;
            exec_done_q   <= 1'b0;
            store_valid_q <= 1'b0;
            store_done_q  <= 1'b0;
            store_data_q  <= '0;
            store_idx_q   <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            load_idx_q    <= load_idx_d;
            i_q           <= i_d;
            j_q           <= j_d;
            k_q           <= k_d;
            for (int e = 0; e < NE; e++) begin
                a_q[e] <= a_d[e];
                b_q[e] <= b_d[e];
                c_q[e] <= c_d[e];
            end
            load_ready_q  <= load_ready_d;
            load_done_q   <= load_done_d;
            exec_done_q   <= exec_done_d;
            store_valid_q <= store_valid_d;
            store_done_q  <= store_done_d;
            store_data_q  <= store_data_d;
            store_idx_q   <= store_idx_d;
        end
    end

    assign bus.load_ready  = load_ready_q;
    assign bus.load_done   = load_done_q;
    assign bus.exec_done   = exec_done_q;
    assign bus.store_valid = store_valid_q;
    assign bus.store_data  = store_data_q;
    assign bus.store_idx   = store_idx_q;
    assign bus.store_done  = store_done_q;
    assign bus.busy        = (state_q != S_IDLE);

endmodule
